// File: rtl/axi_burst_write_master_if.sv
// Bundle of the command, stream, status and AXI4 write-channel signals of the
// burst write master. The master modport is the initiator's view of it.
interface axi_burst_write_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8,
   parameter int LEN_WIDTH  = 16
);
   // command
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [LEN_WIDTH-1:0]  cmd_len;
   logic                  cmd_valid;
   logic                  cmd_ready;
   // word stream
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   // status
   logic                  busy;
   logic                  done;
   logic                  error;
   // AW channel
   logic [ID_WIDTH-1:0]   m_axi_awid;
   logic [ADDR_WIDTH-1:0] m_axi_awaddr;
   logic [7:0]            m_axi_awlen;
   logic [2:0]            m_axi_awsize;
   logic [1:0]            m_axi_awburst;
   logic                  m_axi_awlock;
   logic [3:0]            m_axi_awcache;
   logic [2:0]            m_axi_awprot;
   logic                  m_axi_awvalid;
   logic                  m_axi_awready;
   // W channel
   logic [DATA_WIDTH-1:0] m_axi_wdata;
   logic [STRB_WIDTH-1:0] m_axi_wstrb;
   logic                  m_axi_wlast;
   logic                  m_axi_wvalid;
   logic                  m_axi_wready;
   // B channel
   logic [ID_WIDTH-1:0]   m_axi_bid;
   logic [1:0]            m_axi_bresp;
   logic                  m_axi_bvalid;
   logic                  m_axi_bready;

   modport master (
      input  cmd_addr, cmd_len, cmd_valid, s_data, s_valid,
             m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
      output cmd_ready, s_ready, busy, done, error,
             m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
             m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
             m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready
   );

   modport slave (
      output cmd_addr, cmd_len, cmd_valid, s_data, s_valid,
             m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
      input  cmd_ready, s_ready, busy, done, error,
             m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
             m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
             m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready
   );
endinterface

// File: rtl/axi_burst_write_master.sv
// AXI4 write initiator: splits a (byte address, word count) command into INCR
// bursts of at most MAX_BURST_LEN beats that never cross a 4 KB boundary, and
// streams the input words onto the W channel. One burst is in flight at a time.
module axi_burst_write_master #(
   parameter int                  DATA_WIDTH    = 32,
   parameter int                  ADDR_WIDTH    = 16,
   parameter int                  STRB_WIDTH    = DATA_WIDTH / 8,
   parameter int                  ID_WIDTH      = 8,
   parameter logic [ID_WIDTH-1:0] AXI_ID        = '0,
   parameter int                  MAX_BURST_LEN = 16,
   parameter int                  LEN_WIDTH     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   axi_burst_write_master_if.master bus
);
   localparam int         ADDR_LSB = $clog2(STRB_WIDTH);
   localparam logic [8:0] MAX_BEATS = 9'(MAX_BURST_LEN);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_AW   = 2'd1;
   localparam logic [1:0] S_W    = 2'd2;
   localparam logic [1:0] S_B    = 2'd3;

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_cur_addr;
   logic [LEN_WIDTH-1:0]  r_remaining;
   logic [8:0]            r_beats;      // beats of the burst in flight
   logic [8:0]            r_beat_cnt;   // beats already sent in this burst
   logic                  r_err_acc;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;
   logic                  r_cmd_ready;

   logic [1:0]            w_state_next;
   logic                  w_cmd_fire;
   logic                  w_aw_fire;
   logic                  w_w_fire;
   logic                  w_b_fire;
   logic                  w_last_beat;
   logic                  w_last_burst;
   logic                  w_b_err;
   logic [12:0]           w_room;       // beats left before the next 4 KB line
   logic [8:0]            w_rem_cap;
   logic [8:0]            w_beats;

   assign w_cmd_fire   = (r_state == S_IDLE) && bus.cmd_valid && r_cmd_ready;
   assign w_aw_fire    = (r_state == S_AW) && bus.m_axi_awready;
   assign w_w_fire     = (r_state == S_W) && bus.s_valid && bus.m_axi_wready;
   assign w_b_fire     = (r_state == S_B) && bus.m_axi_bvalid;
   assign w_last_beat  = (r_beat_cnt == r_beats - 9'd1);
   assign w_last_burst = (r_remaining == LEN_WIDTH'(r_beats));
   assign w_b_err      = (bus.m_axi_bresp != 2'b00) || (bus.m_axi_bid != AXI_ID);

   // Burst size is the smallest of words remaining, the burst cap and the room
   // to the 4 KB line; cur_addr and remaining are frozen while in AW, so this is
   // stable for as long as awvalid is held.
   assign w_room    = (13'd4096 - {1'b0, r_cur_addr[11:0]}) >> ADDR_LSB;
   assign w_rem_cap = (r_remaining > LEN_WIDTH'(MAX_BURST_LEN)) ? MAX_BEATS : 9'(r_remaining);
   assign w_beats   = ({4'b0, w_rem_cap} > w_room) ? w_room[8:0] : w_rem_cap;

   // Channel valids/readies derive from the state alone, so an async reset
   // drops them immediately.
   assign bus.cmd_ready     = r_cmd_ready;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.error         = r_error;
   assign bus.m_axi_awid    = AXI_ID;
   assign bus.m_axi_awaddr  = r_cur_addr;
   assign bus.m_axi_awlen   = 8'(w_beats - 9'd1);
   assign bus.m_axi_awsize  = 3'(ADDR_LSB);
   assign bus.m_axi_awburst = 2'b01;
   assign bus.m_axi_awlock  = 1'b0;
   assign bus.m_axi_awcache = 4'b0011;
   assign bus.m_axi_awprot  = 3'b000;
   assign bus.m_axi_awvalid = (r_state == S_AW);
   assign bus.m_axi_wdata   = (r_state == S_W) ? bus.s_data : '0;
   assign bus.m_axi_wstrb   = '1;
   assign bus.m_axi_wlast   = (r_state == S_W) && w_last_beat;
   assign bus.m_axi_wvalid  = (r_state == S_W) && bus.s_valid;
   assign bus.s_ready       = (r_state == S_W) && bus.m_axi_wready;
   assign bus.m_axi_bready  = (r_state == S_B);

   // Next-state logic for the IDLE -> AW -> W -> B loop.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_cmd_fire && (bus.cmd_len != '0)) w_state_next = S_AW;
         S_AW:    if (w_aw_fire) w_state_next = S_W;
         S_W:     if (w_w_fire && w_last_beat) w_state_next = S_B;
         S_B:     if (w_b_fire) w_state_next = w_last_burst ? S_IDLE : S_AW;
         default: w_state_next = S_IDLE;
      endcase
   end

   // State, address/length bookkeeping and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cur_addr  <= '0;
         r_remaining <= '0;
         r_beats     <= '0;
         r_beat_cnt  <= '0;
         r_err_acc   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_cmd_ready <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cmd_ready <= (w_state_next == S_IDLE);
         r_done      <= 1'b0;
         if (w_cmd_fire) begin
            r_cur_addr  <= bus.cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
            r_remaining <= bus.cmd_len;
            r_err_acc   <= 1'b0;
            r_error     <= 1'b0;
            // An empty command completes at once without touching the bus.
            if (bus.cmd_len == '0) r_done <= 1'b1;
            else                   r_busy <= 1'b1;
         end
         if (w_aw_fire) begin
            r_beats    <= w_beats;
            r_beat_cnt <= '0;
         end
         if (w_w_fire) r_beat_cnt <= r_beat_cnt + 9'd1;
         if (w_b_fire) begin
            r_cur_addr  <= r_cur_addr + (ADDR_WIDTH'(r_beats) << ADDR_LSB);
            r_remaining <= r_remaining - LEN_WIDTH'(r_beats);
            r_err_acc   <= r_err_acc | w_b_err;
            if (w_last_burst) begin
               r_done  <= 1'b1;
               r_error <= r_err_acc | w_b_err;
               r_busy  <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_axi_burst_write_master.sv
// Directed bench for axi_burst_write_master: a behavioural AXI slave with a
// word memory, a counting stream source and a table of commands with
// hand-computed burst splits, plus sequences for empty commands and reset.
module tb_axi_burst_write_master;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int IW = 8;
   localparam int LW = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   axi_burst_write_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) bus ();

   axi_burst_write_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .AXI_ID(8'h00),
      .MAX_BURST_LEN(16), .LEN_WIDTH(LW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0]       addr;
      logic [15:0]       len;
      bit                stall;
      int                err_burst;
      bit                exp_err;
      int                nb;
      logic [7:0][15:0]  aw_addr;
      logic [7:0][7:0]   aw_len;
   } vec_t;

   vec_t vecs [8];

   int total_cnt = 0;
   int bad_cnt   = 0;

   // slave / stream model state
   bit          stall_en = 1'b0;
   bit          stream_en = 1'b0;
   int          err_burst = -1;
   int          burst_idx = 0;
   bit          b_pending = 1'b0;
   bit          b_fire = 1'b0;
   logic [31:0] data_base = '0;
   int          stream_idx = 0;
   logic [15:0] wptr = '0;
   logic [31:0] mem [0:16383];
   int          aw_cnt = 0;
   logic [15:0] aw_addr_log [16];
   logic [7:0]  aw_len_log [16];
   int          wlast_cnt = 0;
   int          wlast_pos [16];
   int          beat_total = 0;
   int          done_cnt = 0;
   int          aw_seen = 0;
   logic        last_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] l, input bit st,
                          input int eb, input bit ee, input int nb);
      vecs[i].addr = a; vecs[i].len = l; vecs[i].stall = st;
      vecs[i].err_burst = eb; vecs[i].exp_err = ee; vecs[i].nb = nb;
      vecs[i].aw_addr = '0; vecs[i].aw_len = '0;
   endtask

   // Slave and stream source: new ready/valid values are driven on the falling
   // edge, and 1 time unit later the handshakes that the next rising edge will
   // complete are recorded.
   always @(negedge clk) begin
      if (!rst_n) begin
         bus.m_axi_awready = 1'b0;
         bus.m_axi_wready  = 1'b0;
         bus.m_axi_bvalid  = 1'b0;
         bus.m_axi_bresp   = 2'b00;
         bus.m_axi_bid     = '0;
         bus.s_valid       = 1'b0;
         bus.s_data        = '0;
         b_pending         = 1'b0;
         b_fire            = 1'b0;
      end else begin
         if (b_fire) begin
            bus.m_axi_bvalid = 1'b0;
            b_fire = 1'b0;
            b_pending = 1'b0;
            burst_idx++;
         end
         bus.m_axi_awready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.m_axi_wready  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (b_pending && !bus.m_axi_bvalid && (!stall_en || $urandom_range(0, 1) == 1)) begin
            bus.m_axi_bvalid = 1'b1;
            bus.m_axi_bresp  = (burst_idx == err_burst) ? 2'b10 : 2'b00;
            bus.m_axi_bid    = '0;
         end
         bus.s_valid = stream_en && (!stall_en || $urandom_range(0, 3) != 0);
         bus.s_data  = data_base + 32'(stream_idx);
      end
      #1;
      if (rst_n) begin
         if (bus.done) begin
            done_cnt++;
            last_err = bus.error;
         end
         if (bus.m_axi_awvalid) aw_seen++;
         if (bus.m_axi_awvalid && bus.m_axi_awready) begin
            if (aw_cnt < 16) begin
               aw_addr_log[aw_cnt] = bus.m_axi_awaddr;
               aw_len_log[aw_cnt]  = bus.m_axi_awlen;
            end
            aw_cnt++;
            wptr = bus.m_axi_awaddr;
         end
         if (bus.s_valid && bus.s_ready) stream_idx++;
         if (bus.m_axi_wvalid && bus.m_axi_wready) begin
            mem[wptr[15:2]] = bus.m_axi_wdata;
            wptr = wptr + 16'd4;
            beat_total++;
            if (bus.m_axi_wlast) begin
               if (wlast_cnt < 16) wlast_pos[wlast_cnt] = beat_total;
               wlast_cnt++;
               b_pending = 1'b1;
            end
         end
         if (bus.m_axi_bvalid && bus.m_axi_bready) b_fire = 1'b1;
      end
   end

   task automatic issue_cmd(input logic [15:0] a, input logic [15:0] l);
      int to;
      @(negedge clk);
      bus.cmd_addr  = a;
      bus.cmd_len   = l;
      bus.cmd_valid = 1'b1;
      to = 0;
      while (!bus.cmd_ready && to < 100) begin
         @(negedge clk);
         to++;
      end
      if (to >= 100) begin
         total_cnt++; bad_cnt++;
         $display("FAIL cmd_accept actual=timeout required=cmd_ready");
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #2;
   endtask

   task automatic run_vector(input int i);
      int          to;
      int          d0;
      int          cum;
      int          words_bad;
      logic [15:0] a;
      aw_cnt = 0; wlast_cnt = 0; beat_total = 0; burst_idx = 0; stream_idx = 0;
      stall_en  = vecs[i].stall;
      err_burst = vecs[i].err_burst;
      data_base = 32'hA000_0000 | (32'(i) << 16);
      stream_en = 1'b1;
      d0 = done_cnt;
      issue_cmd(vecs[i].addr, vecs[i].len);
      check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd1);
      check($sformatf("v%0d_cmd_ready_busy", i), 32'(bus.cmd_ready), 32'd0);
      to = 0;
      while (done_cnt == d0 && to < 4000) begin
         @(negedge clk);
         #2;
         to++;
      end
      if (to >= 4000) begin
         total_cnt++; bad_cnt++;
         $display("FAIL v%0d_done actual=timeout required=done", i);
      end
      check($sformatf("v%0d_error", i), 32'(last_err), 32'(vecs[i].exp_err));
      repeat (3) @(negedge clk);
      #2;
      check($sformatf("v%0d_done_pulses", i), 32'(done_cnt - d0), 32'd1);
      check($sformatf("v%0d_busy_end", i), 32'(bus.busy), 32'd0);
      check($sformatf("v%0d_bursts", i), 32'(aw_cnt), 32'(vecs[i].nb));
      check($sformatf("v%0d_wlasts", i), 32'(wlast_cnt), 32'(vecs[i].nb));
      cum = 0;
      for (int b = 0; b < vecs[i].nb && b < aw_cnt && b < 8; b++) begin
         cum += int'(vecs[i].aw_len[b]) + 1;
         check($sformatf("v%0d_awaddr%0d", i, b), 32'(aw_addr_log[b]), 32'(vecs[i].aw_addr[b]));
         check($sformatf("v%0d_awlen%0d", i, b), 32'(aw_len_log[b]), 32'(vecs[i].aw_len[b]));
         check($sformatf("v%0d_wlastpos%0d", i, b), 32'(wlast_pos[b]), 32'(cum));
      end
      words_bad = 0;
      a = vecs[i].addr & 16'hFFFC;
      for (int k = 0; k < int'(vecs[i].len); k++) begin
         if (mem[a[15:2]] !== (data_base + 32'(k))) words_bad++;
         a = a + 16'd4;
      end
      check($sformatf("v%0d_data_words_bad", i), 32'(words_bad), 32'd0);
      stream_en = 1'b0;
      $display("vec %0d addr=%04h len=%0d bursts=%0d error=%0b", i, vecs[i].addr, vecs[i].len, aw_cnt, last_err);
   endtask

   task automatic test_len0();
      int a0;
      int d0;
      stall_en = 1'b0;
      a0 = aw_seen;
      d0 = done_cnt;
      issue_cmd(16'h0400, 16'd0);
      check("len0_done_next_cycle", 32'(bus.done), 32'd1);
      check("len0_error", 32'(bus.error), 32'd0);
      repeat (3) @(negedge clk);
      #2;
      check("len0_done_pulses", 32'(done_cnt - d0), 32'd1);
      check("len0_no_awvalid", 32'(aw_seen - a0), 32'd0);
      $display("len0 cmd done_pulses=%0d aw_cycles=%0d", done_cnt - d0, aw_seen - a0);
   endtask

   task automatic test_reset_mid_w();
      int to;
      stall_en = 1'b0;
      stream_en = 1'b1;
      stream_idx = 0;
      data_base = 32'hB000_0000;
      issue_cmd(16'h3000, 16'd40);
      to = 0;
      while (!bus.m_axi_wvalid && to < 50) begin
         @(negedge clk);
         #2;
         to++;
      end
      check("rst_reached_w", 32'(bus.m_axi_wvalid), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_awvalid", 32'(bus.m_axi_awvalid), 32'd0);
      check("rst_wvalid", 32'(bus.m_axi_wvalid), 32'd0);
      check("rst_bready", 32'(bus.m_axi_bready), 32'd0);
      check("rst_s_ready", 32'(bus.s_ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      stream_en = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #2;
      check("rst_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      $display("reset mid-W burst, cmd_ready=%0b after release", bus.cmd_ready);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;

      set_vec(0, 16'h0000, 16'd40, 1'b0, -1, 1'b0, 3);
      vecs[0].aw_addr[0] = 16'h0000; vecs[0].aw_len[0] = 8'd15;
      vecs[0].aw_addr[1] = 16'h0040; vecs[0].aw_len[1] = 8'd15;
      vecs[0].aw_addr[2] = 16'h0080; vecs[0].aw_len[2] = 8'd7;
      set_vec(1, 16'h0FF0, 16'd8, 1'b0, -1, 1'b0, 2);
      vecs[1].aw_addr[0] = 16'h0FF0; vecs[1].aw_len[0] = 8'd3;
      vecs[1].aw_addr[1] = 16'h1000; vecs[1].aw_len[1] = 8'd3;
      set_vec(2, 16'h0FF3, 16'd8, 1'b0, -1, 1'b0, 2);
      vecs[2].aw_addr[0] = 16'h0FF0; vecs[2].aw_len[0] = 8'd3;
      vecs[2].aw_addr[1] = 16'h1000; vecs[2].aw_len[1] = 8'd3;
      set_vec(3, 16'h0100, 16'd40, 1'b0, 1, 1'b1, 3);
      vecs[3].aw_addr[0] = 16'h0100; vecs[3].aw_len[0] = 8'd15;
      vecs[3].aw_addr[1] = 16'h0140; vecs[3].aw_len[1] = 8'd15;
      vecs[3].aw_addr[2] = 16'h0180; vecs[3].aw_len[2] = 8'd7;
      set_vec(4, 16'h0200, 16'd5, 1'b0, -1, 1'b0, 1);
      vecs[4].aw_addr[0] = 16'h0200; vecs[4].aw_len[0] = 8'd4;
      set_vec(5, 16'hFFF8, 16'd4, 1'b0, -1, 1'b0, 2);
      vecs[5].aw_addr[0] = 16'hFFF8; vecs[5].aw_len[0] = 8'd1;
      vecs[5].aw_addr[1] = 16'h0000; vecs[5].aw_len[1] = 8'd1;
      set_vec(6, 16'h0FC0, 16'd20, 1'b0, -1, 1'b0, 2);
      vecs[6].aw_addr[0] = 16'h0FC0; vecs[6].aw_len[0] = 8'd15;
      vecs[6].aw_addr[1] = 16'h1000; vecs[6].aw_len[1] = 8'd3;
      set_vec(7, 16'h2000, 16'd100, 1'b1, -1, 1'b0, 7);
      for (int b = 0; b < 7; b++) begin
         vecs[7].aw_addr[b] = 16'h2000 + 16'(b * 64);
         vecs[7].aw_len[b]  = (b < 6) ? 8'd15 : 8'd3;
      end

      repeat (3) @(negedge clk);
      #2;
      check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_error", 32'(bus.error), 32'd0);
      check("reset_awvalid", 32'(bus.m_axi_awvalid), 32'd0);
      check("reset_wvalid", 32'(bus.m_axi_wvalid), 32'd0);
      check("reset_bready", 32'(bus.m_axi_bready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #2;
      check("release_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      for (int i = 0; i < 8; i++) begin
         run_vector(i);
         if (i == 3) test_len0();
      end

      test_reset_mid_w();
      run_vector(1);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

   // Backstop against a hung handshake.
   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
